vga_fill_master: RTL and testbench
==================================

# vga_fill_master

Avalon-MM master that fills an axis-aligned rectangle of the 160x120 monochrome frame with one colour by issuing single-beat pixel writes. It is the initiator for the VGA pixel-plot slave: each write targets word address 0 with x, y and colour packed into `writedata`. The block sits between a control source (a CPU register or test FSM) and the VGA slave port. It clips the rectangle to the screen and honours `waitrequest` back-pressure.

## Interface

Parameters:
- `SCREEN_W`, 160, frame width in pixels (max 256)
- `SCREEN_H`, 120, frame height in pixels (max 128)
- `PIXEL_ADDR`, 4'd0, slave word address of the plot register

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a fill; sampled only in IDLE
- `rect_x`  in  8  left column of rectangle
- `rect_y`  in  7  top row of rectangle
- `rect_w`  in  9  width in pixels (0 = empty)
- `rect_h`  in  8  height in pixels (0 = empty)
- `colour`  in  8  fill colour
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`
- `done`  out  1  one-cycle completion pulse
- `m_address`  out  4  Avalon address
- `m_write`  out  1  Avalon write strobe
- `m_writedata`  out  32  Avalon write data
- `m_waitrequest`  in  1  slave stall

## Operation

- All outputs are registered. Reset values: `busy`=0, `done`=0, `m_write`=0, `m_address`=0, `m_writedata`=0. State after reset is IDLE.
- `m_writedata` packing: [30:24]=y, [23:16]=x, [7:0]=colour. All other bits are 0. `m_address`=`PIXEL_ADDR` whenever `m_write`=1.
- States:
  - IDLE: on `start`, latch all rect inputs and `colour`, then compute the clipped bounds.
    - `x_end` = min(`rect_x`+`rect_w`, `SCREEN_W`), 10-bit arithmetic, no overflow.
    - `y_end` = min(`rect_y`+`rect_h`, `SCREEN_H`), 9-bit arithmetic.
    - If `rect_w`=0, `rect_h`=0, `rect_x`>=`SCREEN_W` or `rect_y`>=`SCREEN_H`, go to DONE with no writes.
    - Otherwise go to WRITE with cursor (cx,cy)=(`rect_x`,`rect_y`).
  - WRITE: drive `m_write`=1 and data for the cursor. While `m_waitrequest`=1, hold address, data and `m_write` unchanged. When `m_waitrequest`=0 the beat is accepted and the cursor advances in raster order:
    - cx+1 if cx+1<`x_end`;
    - else cx=`rect_x` and cy+1;
    - after the beat at (`x_end`-1, `y_end`-1), go to DONE.
  - DONE: `m_write`=0, `done`=1 for exactly this one cycle, then IDLE.
- `busy`=1 in WRITE and DONE, 0 in IDLE.
- `start` is ignored while not in IDLE. Input changes after acceptance have no effect.
- Every pixel inside the clipped rectangle is written exactly once. No pixel outside it is written, and no coordinate >= screen bounds ever appears on the bus.
- Reset asserted in any state: at the next edge all outputs return to reset values and state goes to IDLE. The in-flight write is abandoned, and no `done` pulse is produced.

## Timing

- `start` sampled at edge 0 → WRITE entered and first `m_write`=1 visible after edge 0 (cycle 1).
- With `m_waitrequest`=0 constantly, throughput is 1 pixel/cycle. N pixels occupy cycles 1..N, and `done`=1 in cycle N+1. `busy` is high during cycles 1..N+1.
- Each stall cycle (`m_waitrequest`=1 while `m_write`=1) adds exactly one cycle.
- Degenerate or fully-offscreen request: `done`=1 in cycle 1, and `m_write` never asserts.
- Back-to-back: a `start` present in the first IDLE cycle after DONE is accepted.

## Test plan

- Basic fill: `rect_x`=10, `rect_y`=20, `rect_w`=3, `rect_h`=2, `colour`=8'hAA, no stalls → 6 writes in cycles 1–6 with (x,y) sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). First beat `m_writedata`=32'h140A00AA. `done` in cycle 7.
- Back-pressure: same request with `m_waitrequest` high for 2 cycles on every beat → each beat's address/data is held stable for 3 cycles. Still exactly 6 accepted beats, `done` in cycle 19.
- Clipping: `rect_x`=158, `rect_y`=118, `rect_w`=5, `rect_h`=5 → exactly 4 writes, (158,118),(159,118),(158,119),(159,119). No x>=160 or y>=120 appears.
- Empty/offscreen: `rect_w`=0; then `rect_x`=200 → no `m_write` in either case. `done` one cycle after each `start`.
- Start-while-busy and reset mid-fill: a second `start` during WRITE is ignored and the pixel count is unchanged. `reset` asserted after 3 beats of a 10-pixel fill → next cycle `m_write`=0, `busy`=0, no `done`. A fresh `start` then performs a full fill.
- Full screen: `rect_x`=0, `rect_y`=0, `rect_w`=160, `rect_h`=120, no stalls → 19200 beats, last at (159,119), `done` in cycle 19201.

Source files
------------

// File: rtl/vga_fill_master.sv
// Avalon-MM master that fills a clipped rectangle of the frame
// with one colour, one single-beat pixel write per pixel.
module vga_fill_master #(
  parameter int          SCREEN_W   = 160,
  parameter int          SCREEN_H   = 120,
  parameter logic [3:0]  PIXEL_ADDR = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rect_x,
  input  logic [6:0]  rect_y,
  input  logic [8:0]  rect_w,
  input  logic [7:0]  rect_h,
  input  logic [7:0]  colour,
  output logic        busy,
  output logic        done,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [9:0] SW = 10'(SCREEN_W);
  localparam logic [8:0] SH = 9'(SCREEN_H);

  state_t      state_q, state_d;
  logic [7:0]  x0_q, x0_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [9:0]  xend_q, xend_d;
  logic [8:0]  yend_q, yend_d;
  logic [7:0]  col_q, col_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_q, wr_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic [9:0] xsum, xend_in, cx_nx;
  logic [8:0] ysum, yend_in, cy_nx;
  logic       empty;

  function automatic logic [31:0] pack(
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [7:0] c
  );
    return {1'b0, y, x, 8'h00, c};
  endfunction

  // Clipping uses widened sums so x+w and y+h never wrap
  always_comb begin
    xsum    = {2'b00, rect_x} + {1'b0, rect_w};
    ysum    = {2'b00, rect_y} + {1'b0, rect_h};
    xend_in = (xsum < SW) ? xsum : SW;
    yend_in = (ysum < SH) ? ysum : SH;
    empty   = (rect_w == 9'd0) || (rect_h == 8'd0) ||
              ({2'b00, rect_x} >= SW) ||
              ({2'b00, rect_y} >= SH);
    cx_nx   = {2'b00, cx_q} + 10'd1;
    cy_nx   = {2'b00, cy_q} + 9'd1;
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          x0_d   = rect_x;
          cx_d   = rect_x;
          cy_d   = rect_y;
          xend_d = xend_in;
          yend_d = yend_in;
          col_d  = colour;
          busy_d = 1'b1;
          if (empty) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            addr_d  = PIXEL_ADDR;
            data_d  = pack(rect_x, rect_y, colour);
          end
        end
      end
      S_WRITE: begin
        if (!m_waitrequest) begin
          if (cx_nx < xend_q) begin
            cx_d   = cx_nx[7:0];
            data_d = pack(cx_nx[7:0], cy_q, col_q);
          end else if (cy_nx < yend_q) begin
            cx_d   = x0_q;
            cy_d   = cy_nx[6:0];
            data_d = pack(x0_q, cy_nx[6:0], col_q);
          end else begin
            state_d = S_DONE;
            wr_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xend_q  <= '0;
      yend_q  <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign m_write     = wr_q;
  assign m_address   = addr_q;
  assign m_writedata = data_q;

endmodule

// File: tb/tb_vga_fill_master.sv
// Directed bench for vga_fill_master: raster order, clipping,
// back-pressure, empty requests, start-while-busy and reset.
module tb_vga_fill_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rect_x;
  logic [6:0]  rect_y;
  logic [8:0]  rect_w;
  logic [7:0]  rect_h;
  logic [7:0]  colour;
  logic        busy;
  logic        done;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  int n_chk  = 0;
  int n_pass = 0;

  int bx[$];
  int by[$];
  int bc[$];
  logic [31:0] first_data;

  always #5 clk = ~clk;

  vga_fill_master dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rect_x        (rect_x),
    .rect_y        (rect_y),
    .rect_w        (rect_w),
    .rect_h        (rect_h),
    .colour        (colour),
    .busy          (busy),
    .done          (done),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One fill from start to done; expected beats from a plain raster loop
  task automatic run_fill(
    input string      tag,
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [8:0] w,
    input logic [7:0] h,
    input logic [7:0] c,
    input bit         stall,
    input bit         glitch,
    input int         n_exp,
    input int         done_exp,
    input logic [31:0] first_exp
  );
    int dcyc, st, xe, ye, k;
    bit prev_stall, hold_ok, oob, busy_ok, seq_ok;
    logic [31:0] prev;
    bx.delete(); by.delete(); bc.delete();
    first_data = '0;
    @(negedge clk);
    rect_x = x; rect_y = y; rect_w = w; rect_h = h;
    colour = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = -1; st = 0; prev_stall = 0; prev = '0;
    hold_ok = 1; oob = 0; busy_ok = 1;
    for (int cyc = 1; cyc <= 25000 && dcyc < 0; cyc++) begin
      @(negedge clk);
      if (glitch) begin
        start  = (cyc == 2);
        rect_w = 9'd50;
      end
      if (!busy) busy_ok = 0;
      m_waitrequest = stall && m_write && (st < 2);
      if (m_waitrequest) st++;
      else st = 0;
      if (m_write) begin
        if (prev_stall && m_writedata !== prev) hold_ok = 0;
        if (m_writedata[23:16] >= 8'd160 ||
            m_writedata[30:24] >= 7'd120 ||
            m_writedata[31] || m_writedata[15:8] != 8'h00 ||
            m_address != 4'd0) oob = 1;
        if (!m_waitrequest) begin
          if (bx.size() == 0) first_data = m_writedata;
          bx.push_back(int'(m_writedata[23:16]));
          by.push_back(int'(m_writedata[30:24]));
          bc.push_back(int'(m_writedata[7:0]));
        end
      end
      prev_stall = m_write && m_waitrequest;
      prev = m_writedata;
      if (done) dcyc = cyc;
    end
    m_waitrequest = 1'b0;
    start = 1'b0;
    chk({tag, " beats"}, bx.size(), n_exp);
    chk({tag, " done_cyc"}, dcyc, done_exp);
    chk({tag, " hold"}, hold_ok, 1);
    chk({tag, " bounds"}, oob, 0);
    chk({tag, " busy"}, busy_ok, 1);
    if (n_exp > 0) chk({tag, " first"}, first_data, first_exp);
    xe = int'(x) + int'(w);
    if (xe > 160) xe = 160;
    ye = int'(y) + int'(h);
    if (ye > 120) ye = 120;
    seq_ok = 1; k = 0;
    for (int yy = int'(y); yy < ye; yy++)
      for (int xx = int'(x); xx < xe; xx++) begin
        if (k >= bx.size()) seq_ok = 0;
        else if (bx[k] != xx || by[k] != yy || bc[k] != int'(c))
          seq_ok = 0;
        k++;
      end
    chk({tag, " seq"}, seq_ok, 1);
    @(negedge clk);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; m_waitrequest = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
    colour = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst m_write", m_write, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst data", m_writedata, 32'h0);
    chk("rst addr", m_address, 0);
    reset = 1'b0;

    run_fill("basic", 8'd10, 7'd20, 9'd3, 8'd2, 8'hAA,
             0, 0, 6, 7, 32'h140A00AA);
    run_fill("stall", 8'd10, 7'd20, 9'd3, 8'd2, 8'hAA,
             1, 0, 6, 19, 32'h140A00AA);
    run_fill("clip", 8'd158, 7'd118, 9'd5, 8'd5, 8'h3C,
             0, 0, 4, 5, 32'h769E003C);
    run_fill("w0", 8'd5, 7'd5, 9'd0, 8'd4, 8'h11,
             0, 0, 0, 1, 32'h0);
    run_fill("offx", 8'd200, 7'd5, 9'd4, 8'd4, 8'h22,
             0, 0, 0, 1, 32'h0);
    run_fill("glitch", 8'd10, 7'd20, 9'd3, 8'd2, 8'h55,
             0, 1, 6, 7, 32'h140A0055);

    // Reset after three accepted beats of a 10-pixel fill
    @(negedge clk);
    rect_x = 8'd0; rect_y = 7'd0; rect_w = 9'd10; rect_h = 8'd1;
    colour = 8'h77; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst write", m_write, 1);
    chk("pre_rst x", m_writedata[23:16], 8'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst write", m_write, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    reset = 1'b0;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || m_write) saw_done = 1;
    end
    chk("post_rst quiet", saw_done, 0);
    run_fill("refill", 8'd0, 7'd0, 9'd10, 8'd1, 8'h77,
             0, 0, 10, 11, 32'h00000077);

    run_fill("full", 8'd0, 7'd0, 9'd160, 8'd120, 8'hFF,
             0, 0, 19200, 19201, 32'h000000FF);
    chk("full last_x", bx[bx.size()-1], 159);
    chk("full last_y", by[by.size()-1], 119);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
